// File: rtl/debug_clock_sequencer.sv
// ---------------------------------------------------------------------------
// debug_clock_sequencer: host-debugger command decoder and CPU clk/iclk/reset
// sequencer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module debug_clock_sequencer #(
  parameter int PULSE_W = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] evt_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  input  logic       brk,
  input  logic       hlt,
  output logic       cpu_clk,
  output logic       cpu_iclk,
  output logic       cpu_rst,
  output logic       ctrlen
);

  localparam int            c_cw      = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [c_cw-1:0] c_cnt_max = c_cw'(PULSE_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARG, S_PULSE, S_RUN, S_STEP, S_RSTSEQ, S_REPORT
  } state_e;

  typedef enum logic [1:0] {
    PH_CLK_HI, PH_CLK_LO, PH_ICLK_HI, PH_ICLK_LO
  } phase_e;

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  phase_e          last_ph_q, last_ph_d;
  logic [c_cw-1:0] cnt_q, cnt_d;
  logic [8:0]      step_q, step_d;
  logic            stop_q, stop_d;
  logic [7:0]      evt_data_q, evt_data_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            evt_valid_q, evt_valid_d;
  logic            cpu_clk_q, cpu_clk_d;
  logic            cpu_iclk_q, cpu_iclk_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic            ctrlen_q, ctrlen_d;

  logic w_accept;
  logic w_phase_end;
  logic w_active_d;

  assign w_accept    = cmd_valid & cmd_ready_q;
  assign w_phase_end = (cnt_q == c_cnt_max);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    last_ph_d  = last_ph_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    stop_d     = stop_q;
    evt_data_d = evt_data_q;

    if (state_q inside {S_PULSE, S_RUN, S_STEP, S_RSTSEQ}) begin
      if (w_phase_end) begin
        cnt_d   = '0;
        phase_d = phase_e'(phase_q + 2'd1);
      end else begin
        cnt_d = cnt_q + c_cw'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          cnt_d = '0;
          case (cmd_data)
            8'h63: begin state_d = S_PULSE; phase_d = PH_CLK_HI;  last_ph_d = PH_CLK_LO;  end
            8'h43: begin state_d = S_PULSE; phase_d = PH_ICLK_HI; last_ph_d = PH_ICLK_LO; end
            8'h54: begin state_d = S_PULSE; phase_d = PH_CLK_HI;  last_ph_d = PH_ICLK_LO; end
            8'h53: state_d = S_ARG;
            8'h52: begin state_d = S_RUN;    phase_d = PH_CLK_HI; stop_d = 1'b0; end
            8'h5A: begin state_d = S_RSTSEQ; phase_d = PH_CLK_HI; end
            8'h4E, 8'hFF: state_d = S_IDLE;
            default: begin state_d = S_REPORT; evt_data_d = 8'h3F; end
          endcase
        end
      end
      S_ARG: begin
        if (w_accept) begin
          state_d = S_STEP;
          phase_d = PH_CLK_HI;
          cnt_d   = '0;
          stop_d  = 1'b0;
          step_d  = (cmd_data == 8'd0) ? 9'd256 : {1'b0, cmd_data};
        end
      end
      S_PULSE: begin
        if (w_phase_end && (phase_q == last_ph_q)) state_d = S_IDLE;
      end
      S_RSTSEQ: begin
        if (w_phase_end && (phase_q == PH_ICLK_LO)) state_d = S_IDLE;
      end
      S_RUN, S_STEP: begin
        // Stop request is latched late in ICLK_HI so the current tick always completes.
        if (w_phase_end && (phase_q == PH_ICLK_HI) && (brk || !hlt)) begin
          stop_d     = 1'b1;
          evt_data_d = brk ? 8'h42 : 8'h48;
        end
        if (w_phase_end && (phase_q == PH_ICLK_LO)) begin
          if (stop_q) begin
            state_d = S_REPORT;
            stop_d  = 1'b0;
            step_d  = '0;
          end else if (state_q == S_STEP) begin
            step_d = step_q - 9'd1;
            if (step_q == 9'd1) begin
              state_d    = S_REPORT;
              evt_data_d = 8'h53;
            end
          end
        end
      end
      S_REPORT: begin
        if (evt_valid_q && evt_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    w_active_d  = state_d inside {S_PULSE, S_RUN, S_STEP, S_RSTSEQ};
    cpu_clk_d   = w_active_d && (phase_d == PH_CLK_HI);
    cpu_iclk_d  = w_active_d && (phase_d == PH_ICLK_HI);
    cpu_rst_d   = (state_d == S_RSTSEQ);
    ctrlen_d    = !((state_d == S_RUN) || (state_d == S_STEP));
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_ARG);
    evt_valid_d = (state_d == S_REPORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_CLK_HI;
      last_ph_q   <= PH_CLK_HI;
      cnt_q       <= '0;
      step_q      <= '0;
      stop_q      <= 1'b0;
      evt_data_q  <= 8'h00;
      cmd_ready_q <= 1'b0;
      evt_valid_q <= 1'b0;
      cpu_clk_q   <= 1'b0;
      cpu_iclk_q  <= 1'b0;
      cpu_rst_q   <= 1'b0;
      ctrlen_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      last_ph_q   <= last_ph_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      stop_q      <= stop_d;
      evt_data_q  <= evt_data_d;
      cmd_ready_q <= cmd_ready_d;
      evt_valid_q <= evt_valid_d;
      cpu_clk_q   <= cpu_clk_d;
      cpu_iclk_q  <= cpu_iclk_d;
      cpu_rst_q   <= cpu_rst_d;
      ctrlen_q    <= ctrlen_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign evt_data  = evt_data_q;
  assign evt_valid = evt_valid_q;
  assign cpu_clk   = cpu_clk_q;
  assign cpu_iclk  = cpu_iclk_q;
  assign cpu_rst   = cpu_rst_q;
  assign ctrlen    = ctrlen_q;

endmodule

`default_nettype wire

// File: tb/tb_debug_clock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_debug_clock_sequencer: directed self-checking bench for the sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_debug_clock_sequencer;

  localparam int PW = 2;
  localparam int TK = 4 * PW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] evt_data;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic       brk = 1'b0;
  logic       hlt = 1'b1;
  logic       cpu_clk;
  logic       cpu_iclk;
  logic       cpu_rst;
  logic       ctrlen;

  int checks = 0;
  int errors = 0;

  debug_clock_sequencer #(.PULSE_W(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .evt_data  (evt_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .brk       (brk),
    .hlt       (hlt),
    .cpu_clk   (cpu_clk),
    .cpu_iclk  (cpu_iclk),
    .cpu_rst   (cpu_rst),
    .ctrlen    (ctrlen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one cycle after the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 3000) begin
      cyc();
      n++;
    end
    check("send_wait", 32'(n < 3000), 32'd1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic accept_evt();
    evt_ready = 1'b1;
    cyc();
    evt_ready = 1'b0;
    check("evt_drop", 32'(evt_valid), 32'd0);
    check("evt_rdy", 32'(cmd_ready), 32'd1);
  endtask

  // Counts ticks until an event shows, optionally injecting brk/hlt at a tick start.
  task automatic monitor(input int brk_tick, input int hlt_tick, input int stop_at,
                         input int max_cyc, output int ticks, output int cycles,
                         output bit ctrl_ok, output bit ovl);
    logic prev;
    prev    = 1'b0;
    ticks   = 0;
    cycles  = 0;
    ctrl_ok = 1'b1;
    ovl     = 1'b0;
    while (cycles < max_cyc) begin
      cycles++;
      if (evt_valid) break;
      if (cpu_clk && !prev) begin
        ticks++;
        if (ticks == brk_tick) brk = 1'b1;
        if (ticks == hlt_tick) hlt = 1'b0;
        if (ticks == stop_at) break;
      end
      if (ctrlen) ctrl_ok = 1'b0;
      if (cpu_clk && cpu_iclk) ovl = 1'b1;
      prev = cpu_clk;
      cyc();
    end
    check("mon_timeout", 32'(cycles < max_cyc), 32'd1);
    brk = 1'b0;
    hlt = 1'b1;
  endtask

  initial begin
    int  t, c;
    bit  ok, ov;

    // Reset defaults
    repeat (3) cyc();
    check("rst_ctrlen", 32'(ctrlen), 32'd1);
    check("rst_clk", 32'(cpu_clk), 32'd0);
    check("rst_iclk", 32'(cpu_iclk), 32'd0);
    check("rst_cpurst", 32'(cpu_rst), 32'd0);
    check("rst_evtv", 32'(evt_valid), 32'd0);
    check("rst_evtd", 32'(evt_data), 32'd0);
    check("rst_rdy", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_rdy_rel", 32'(cmd_ready), 32'd0);
    cyc();
    check("rst_rdy_1", 32'(cmd_ready), 32'd1);

    // Full tick: clk cycles 1..PW, iclk cycles 2PW+1..3PW
    send_byte(8'h54);
    for (int i = 1; i <= TK; i++) begin
      check("T_clk", 32'(cpu_clk), 32'((i <= PW)));
      check("T_iclk", 32'(cpu_iclk), 32'((i > 2 * PW) && (i <= 3 * PW)));
      check("T_ctrlen", 32'(ctrlen), 32'd1);
      check("T_rdy", 32'(cmd_ready), 32'd0);
      cyc();
    end
    check("T_rdy_back", 32'(cmd_ready), 32'd1);
    check("T_clk_end", 32'(cpu_clk), 32'd0);

    // Single clk pulse and single iclk pulse
    send_byte(8'h63);
    for (int i = 1; i <= 2 * PW; i++) begin
      check("c_clk", 32'(cpu_clk), 32'((i <= PW)));
      check("c_iclk", 32'(cpu_iclk), 32'd0);
      cyc();
    end
    check("c_rdy_back", 32'(cmd_ready), 32'd1);
    send_byte(8'h43);
    for (int i = 1; i <= 2 * PW; i++) begin
      check("C_iclk", 32'(cpu_iclk), 32'((i <= PW)));
      check("C_clk", 32'(cpu_clk), 32'd0);
      cyc();
    end
    check("C_rdy_back", 32'(cmd_ready), 32'd1);

    // Step 3, clean completion
    send_byte(8'h53);
    send_byte(8'h03);
    monitor(0, 0, 0, 500, t, c, ok, ov);
    check("S3_ticks", 32'(t), 32'd3);
    check("S3_cycles", 32'(c), 32'(3 * TK + 1));
    check("S3_ctrlen0", 32'(ok), 32'd1);
    check("S3_overlap", 32'(ov), 32'd0);
    check("S3_evt", 32'(evt_data), 32'h53);
    check("S3_ctrlen1", 32'(ctrlen), 32'd1);
    accept_evt();

    // Step 3 with halt during tick 2
    send_byte(8'h53);
    send_byte(8'h03);
    monitor(0, 2, 0, 500, t, c, ok, ov);
    check("SH_ticks", 32'(t), 32'd2);
    check("SH_cycles", 32'(c), 32'(2 * TK + 1));
    check("SH_evt", 32'(evt_data), 32'h48);
    accept_evt();
    repeat (3) cyc();
    check("SH_no53", 32'(evt_valid), 32'd0);

    // brk and halt together: break wins
    send_byte(8'h53);
    send_byte(8'h05);
    monitor(1, 1, 0, 500, t, c, ok, ov);
    check("SB_ticks", 32'(t), 32'd1);
    check("SB_evt", 32'(evt_data), 32'h42);
    accept_evt();

    // Run with break in tick 5, event held while host stalls
    send_byte(8'h52);
    check("R_ctrlen0", 32'(ctrlen), 32'd0);
    monitor(5, 0, 0, 500, t, c, ok, ov);
    check("R_ticks", 32'(t), 32'd5);
    check("R_cycles", 32'(c), 32'(5 * TK + 1));
    check("R_ctrl_ok", 32'(ok), 32'd1);
    check("R_overlap", 32'(ov), 32'd0);
    check("R_ctrlen1", 32'(ctrlen), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("R_hold_v", 32'(evt_valid), 32'd1);
      check("R_hold_d", 32'(evt_data), 32'h42);
      check("R_hold_rdy", 32'(cmd_ready), 32'd0);
      check("R_no_clk", 32'(cpu_clk), 32'd0);
      cyc();
    end
    accept_evt();

    // Reset sequence
    send_byte(8'h5A);
    for (int i = 1; i <= TK; i++) begin
      check("Z_rst", 32'(cpu_rst), 32'd1);
      check("Z_clk", 32'(cpu_clk), 32'((i <= PW)));
      check("Z_evt", 32'(evt_valid), 32'd0);
      cyc();
    end
    check("Z_rst_end", 32'(cpu_rst), 32'd0);
    check("Z_rdy", 32'(cmd_ready), 32'd1);
    check("Z_noevt", 32'(evt_valid), 32'd0);

    // Unknown, then ignored commands
    send_byte(8'h7A);
    check("U_v", 32'(evt_valid), 32'd1);
    check("U_d", 32'(evt_data), 32'h3F);
    check("U_rdy", 32'(cmd_ready), 32'd0);
    accept_evt();
    send_byte(8'hFF);
    check("FF_v", 32'(evt_valid), 32'd0);
    check("FF_rdy", 32'(cmd_ready), 32'd1);
    check("FF_clk", 32'(cpu_clk), 32'd0);
    send_byte(8'h4E);
    cyc();
    check("N_v", 32'(evt_valid), 32'd0);
    check("N_rdy", 32'(cmd_ready), 32'd1);

    // N = 0 means 256 steps
    send_byte(8'h53);
    send_byte(8'h00);
    monitor(0, 0, 0, 3000, t, c, ok, ov);
    check("S0_ticks", 32'(t), 32'd256);
    check("S0_cycles", 32'(c), 32'(256 * TK + 1));
    check("S0_evt", 32'(evt_data), 32'h53);
    accept_evt();

    // Reset in the middle of tick 100
    send_byte(8'h53);
    send_byte(8'h00);
    monitor(0, 0, 100, 3000, t, c, ok, ov);
    check("MR_at", 32'(t), 32'd100);
    check("MR_clk_pre", 32'(cpu_clk), 32'd1);
    rst_n = 1'b0;
    #1;
    check("MR_ctrlen", 32'(ctrlen), 32'd1);
    check("MR_clk", 32'(cpu_clk), 32'd0);
    check("MR_iclk", 32'(cpu_iclk), 32'd0);
    check("MR_rdy", 32'(cmd_ready), 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("MR_noevt", 32'(evt_valid), 32'd0);
      check("MR_noclk", 32'(cpu_clk | cpu_iclk), 32'd0);
    end
    check("MR_rdy_back", 32'(cmd_ready), 32'd1);
    check("MR_ctrlen_back", 32'(ctrlen), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/debug_clock_sequencer.md
# debug_clock_sequencer

Synthesizable sequencer that owns the CPU's `clk`/`iclk` phase generation and decides whether the CPU free-runs or sits under host debugger control. It takes single-byte debugger commands over a valid/ready stream and emits single-byte event codes. Between the host link and the CPU core it:
- drives `ctrlen` (debugger owns control word and buses);
- produces clock pulses and single steps;
- stops the CPU on break or halt;
- sequences the CPU reset.

## Interface
- `PULSE_W`, default 1: system clocks per phase (high or low) of each generated pulse; must be ≥1.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_data`  in  8  debugger command byte.
- `cmd_valid`  in  1  command byte present.
- `cmd_ready`  out  1  sequencer accepts a byte this cycle.
- `evt_data`  out  8  event code.
- `evt_valid`  out  1  event code present; held until accepted.
- `evt_ready`  in  1  host takes the event.
- `brk`  in  1  breakpoint request, active high.
- `hlt`  in  1  CPU halt, active low (halted when 0).
- `cpu_clk`  out  1  generated CPU data clock.
- `cpu_iclk`  out  1  generated CPU instruction/control clock.
- `cpu_rst`  out  1  CPU reset, active high.
- `ctrlen`  out  1  1 = debugger owns control word and buses.

## Operation
- **Tick:** four phases of `PULSE_W` cycles each, in this order:
  - CLK_HI (`cpu_clk`=1)
  - CLK_LO
  - ICLK_HI (`cpu_iclk`=1)
  - ICLK_LO
- **Reset:** `ctrlen`=1, state IDLE. Every other output is 0; this includes `cpu_clk`, `cpu_iclk`, `cpu_rst`, `evt_valid`, `cmd_ready` and `evt_data`. `cmd_ready` rises on the first clock after `rst_n` deasserts.
- **State machine:** IDLE, ARG, PULSE (sub-phase counter), RUN, STEP, RSTSEQ, REPORT.
- **Command acceptance:** `cmd_ready`=1 only in IDLE and ARG. The command is decoded in the cycle of `cmd_valid & cmd_ready`.
- **Commands accepted in IDLE:**
  - `'c'` (0x63): one clk pulse only (CLK_HI, CLK_LO), then IDLE.
  - `'C'` (0x43): one iclk pulse only (ICLK_HI, ICLK_LO), then IDLE.
  - `'T'` (0x54): one full tick, then IDLE. `ctrlen` stays 1.
  - `'S'` (0x53): go to ARG. The next byte N is the step count; N=0 means 256. Then STEP: `ctrlen`=0 and N ticks. On completion, `ctrlen`=1 and report 0x53.
  - `'R'` (0x52): `ctrlen`=0, RUN with continuous ticks.
  - `'Z'` (0x5A): RSTSEQ. `cpu_rst`=1 for one full tick, then `cpu_rst`=0 in the cycle after ICLK_LO ends, then IDLE. No event.
  - `'N'` (0x4E) and 0xFF: ignored; stay in IDLE.
  - Any other byte: report 0x3F (`'?'`).
- **Stop check:** in RUN and STEP, `brk` and `hlt` are sampled in the last cycle of ICLK_HI.
  - If `brk`=1: finish the tick, `ctrlen`=1, report 0x42 (`'B'`).
  - Else if `hlt`=0: same, but report 0x48 (`'H'`).
  - When `brk`=1 and `hlt`=0 together, only 0x42 is reported.
  - A stop during STEP ends STEP early and suppresses the 0x53 report.
- **REPORT:** `evt_valid`=1 with `evt_data` stable until `evt_valid & evt_ready`, then IDLE. No commands are accepted while in REPORT.
- **Step counter:** 9-bit down-counter loaded with N, or with 256 when N=0. Decrements at the end of each ICLK_LO. STEP ends when it reaches 0.

## Timing
- **Command latency:** the first phase output changes in the cycle after the command handshake.
- **Pulse width:** each phase lasts exactly `PULSE_W` cycles.
- **Tick length:** 4·`PULSE_W` cycles. In RUN, ticks are back-to-back with no gap cycles.
- **`ctrlen` falling (`'R'`, STEP start):** falls in the same cycle CLK_HI of the first tick starts.
- **`ctrlen` rising:** rises in the cycle after the final ICLK_LO, together with the transition to REPORT or IDLE.
- **`cpu_clk` and `cpu_iclk`:** never high in the same cycle.
- **Outputs:** all are registered; no combinational path from inputs to outputs except none.
- **Mid-operation reset:** asserting `rst_n` low mid-tick forces the reset values asynchronously, including `ctrlen`=1. A pending event is dropped and the step count cleared.
- **Command bytes during PULSE/RUN/STEP/RSTSEQ/REPORT:** `cmd_ready`=0; the byte is held by the sender.
- **`evt_ready` while not in REPORT:** no effect.

## Test plan
- **Reset defaults:** `rst_n` low then high, `PULSE_W`=1 -> `ctrlen`=1, `cpu_clk`=`cpu_iclk`=`cpu_rst`=0, `cmd_ready`=1 one cycle after release.
- **Tick:** send `'T'` with `PULSE_W`=2 -> `cpu_clk` high for 2 cycles, low for 2, `cpu_iclk` high for 2, low for 2. `ctrlen` stays 1. `cmd_ready` returns 1 eight cycles after the handshake.
- **Step with early halt:** send `'S'`,0x03 with `hlt`=1 -> exactly 3 ticks, `ctrlen`=0 throughout, then event 0x53. Repeat with `hlt`=0 during tick 2 -> 2 ticks, event 0x48, no 0x53.
- **Run and break:** send `'R'`, assert `brk` during tick 5 ICLK_HI -> tick 5 completes, no 6th CLK_HI, `ctrlen`=1, event 0x42. `evt_ready` held low 10 cycles -> `evt_valid` and 0x42 stay stable, `cmd_ready`=0.
- **Reset sequence and unknown command:** send `'Z'` -> `cpu_rst`=1 across one full tick, then 0, no event. Send 0x7A -> event 0x3F. Send 0xFF -> no event, IDLE.
- **N=0 and mid-step reset:** send `'S'`,0x00 -> 256 ticks then event 0x53. Pull `rst_n` low during tick 100 of a repeat -> `ctrlen`=1 immediately, clocks 0, no event after release.
